rk_bus_disk_write: RTL and testbench

Receives the composite write-data/clock stream from the CPU disk bus during a write, and deserializes it into 16-bit words for the SDRAM controller. Sits between the bus receivers and the SDRAM controller in the RK05/2315 emulator. It detects the sync pattern, checks each 20-bit word (16 data bits plus 4 check bits), and issues address-load and per-word write strobes. It also drives the WT indicator, the write interrupt qualifier and an emulated Write Clock B.

---
 rtl/rk_bus_disk_write_pkg.sv | 14 +
 rtl/rk_bus_disk_write_bit_recover.sv | 34 +++
 rtl/rk_bus_disk_write.sv | 138 +++++++++++++
 tb/tb_rk_bus_disk_write.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rk_bus_disk_write_pkg.sv
// rk_bus_disk_write_pkg: shared constants, state enum and mod-4 parity helper for the bus write path
package rk_bus_disk_write_pkg;
    localparam int WORDS_PER_SECTOR = 321;
    localparam int BITS_PER_WORD = 20;
    localparam int SYNC_TAIL_BITS = 4;
    localparam int CLKB_HALF_CYCLES = 29;
    typedef enum logic [2:0] {ST_IDLE, ST_PREAMBLE, ST_SYNC, ST_DATA, ST_DONE} state_e;
    function automatic logic [1:0] ones_mod4(input logic [19:0] v);
        logic [1:0] s;
        s = '0;
        for (int i = 0; i < 20; i++) s += 2'(v[i]);
        return s;
    endfunction
endpackage

// File: rtl/rk_bus_disk_write_bit_recover.sv
// rk_wt_bit_recover: synchronizes the write bus and recovers one bit per falling CLOCKB edge
module rk_wt_bit_recover (
    input  logic clock,
    input  logic reset,
    input  logic gate_l_i,
    input  logic data_clk_l_i,
    input  logic clockb_l_i,
    output logic gate_l_o,
    output logic bit_valid_o,
    output logic bit_value_o
);
    logic [1:0] gate_q, data_q, clkb_q;
    logic clkb_prev_q, one_q, one_d;
    always_ff @(posedge clock) begin
        if (reset) begin
            gate_q <= 2'b11;
            data_q <= 2'b11;
            clkb_q <= 2'b00;
            clkb_prev_q <= 1'b0;
            one_q <= 1'b0;
        end else begin
            gate_q <= {gate_q[0], gate_l_i};
            data_q <= {data_q[0], data_clk_l_i};
            clkb_q <= {clkb_q[0], clockb_l_i};
            clkb_prev_q <= clkb_q[1];
            one_q <= one_d;
        end
    end
    // The edge cycle itself has CLOCKB low, so it can never set the one-latch.
    assign bit_valid_o = clkb_prev_q & ~clkb_q[1];
    assign one_d = bit_valid_o ? 1'b0 : one_q | (clkb_q[1] & ~data_q[1]);
    assign bit_value_o = one_q;
    assign gate_l_o = gate_q[1];
endmodule

// File: rtl/rk_bus_disk_write.sv
// rk_bus_disk_write: deserializes bus write data into 16-bit SDRAM words with sync detect and strobes.
// Define ECC_CHECK_EN to enable the mod-4 check-bit test and sticky ECC_error.
module rk_bus_disk_write
    import rk_bus_disk_write_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        BUS_WT_GATE_L,
    input  logic        BUS_WT_DATA_CLK_L,
    input  logic        BUS_WT_CLOCKB_L,
    input  logic        Selected_Ready,
    input  logic        real_drive,
    input  logic        clkenbl_sector,
    output logic        dram_write_enbl_buswrite,
    output logic [15:0] dram_writedata_buswrite,
    output logic        load_address_buswrite,
    output logic        write_indicator,
    output logic        write_selected_ready,
    output logic        ECC_error,
    output logic        BUS_WT_CLOCKB_EMUL_L
);
    state_e state_q, state_d;
    logic [18:0] sr_q, sr_d;
    logic [19:0] sr_nx;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [8:0] word_cnt_q, word_cnt_d;
    logic [15:0] wdata_q, wdata_d;
    logic [5:0] pc_q, pc_d;
    logic wen_q, wen_d, ld_q, ld_d, ind_q, emul_q, emul_d;
    logic gate_s, bit_valid, bit_value, active, take, emul_en;

    rk_wt_bit_recover u_rec (
        .clock(clock), .reset(reset), .gate_l_i(BUS_WT_GATE_L), .data_clk_l_i(BUS_WT_DATA_CLK_L),
        .clockb_l_i(BUS_WT_CLOCKB_L), .gate_l_o(gate_s), .bit_valid_o(bit_valid), .bit_value_o(bit_value)
    );

    assign active = ~gate_s & Selected_Ready;
    assign take = active & bit_valid;
    assign sr_nx = {sr_q, bit_value};
    assign emul_en = ~real_drive & active;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q <= '0;
            bit_cnt_q <= '0;
            word_cnt_q <= '0;
            wdata_q <= '0;
            wen_q <= 1'b0;
            ld_q <= 1'b0;
            ind_q <= 1'b0;
            pc_q <= '0;
            emul_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sr_q <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            wdata_q <= wdata_d;
            wen_q <= wen_d;
            ld_q <= ld_d;
            ind_q <= active;
            pc_q <= pc_d;
            emul_q <= emul_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d = sr_q;
        bit_cnt_d = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        wdata_d = wdata_q;
        wen_d = 1'b0;
        ld_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                word_cnt_d = '0;
                bit_cnt_d = '0;
                if (active) state_d = ST_PREAMBLE;
            end
            ST_PREAMBLE: if (take && bit_value) begin
                sr_d = 19'd1;
                bit_cnt_d = '0;
                state_d = ST_SYNC;
            end
            ST_SYNC: if (take) begin
                sr_d = sr_nx[18:0];
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'(SYNC_TAIL_BITS - 1)) begin
                    ld_d = 1'b1;
                    bit_cnt_d = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: if (take) begin
                sr_d = sr_nx[18:0];
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'(BITS_PER_WORD - 1)) begin
                    wdata_d = sr_nx[19:4];
                    wen_d = 1'b1;
                    bit_cnt_d = '0;
                    word_cnt_d = word_cnt_q + 9'd1;
                    if (word_cnt_q == 9'(WORDS_PER_SECTOR - 1)) state_d = ST_DONE;
                end
            end
            default: ;
        endcase
        // A word finishing alongside the sector pulse still gets its strobe above.
        if (!active || (clkenbl_sector && state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    always_comb begin
        pc_d = emul_en ? ((pc_q == 6'(2 * CLKB_HALF_CYCLES - 1)) ? 6'd0 : pc_q + 6'd1) : 6'd0;
        emul_d = emul_en ? (pc_q >= 6'(CLKB_HALF_CYCLES)) : 1'b1;
    end

`ifdef ECC_CHECK_EN
    logic ecc_q, ecc_d, ecc_chk;
    assign ecc_chk = take & ((state_q == ST_SYNC && bit_cnt_q == 5'(SYNC_TAIL_BITS - 1)) ||
                             (state_q == ST_DATA && bit_cnt_q == 5'(BITS_PER_WORD - 1)));
    assign ecc_d = (state_q == ST_IDLE && active) ? 1'b0 : ecc_q | (ecc_chk && ones_mod4(sr_nx) != 2'd0);
    always_ff @(posedge clock) begin
        if (reset) ecc_q <= 1'b0;
        else ecc_q <= ecc_d;
    end
    assign ECC_error = ecc_q;
`else
    assign ECC_error = 1'b0;
`endif

    assign dram_write_enbl_buswrite = wen_q;
    assign dram_writedata_buswrite = wdata_q;
    assign load_address_buswrite = ld_q;
    assign write_indicator = ind_q;
    assign write_selected_ready = ind_q;
    assign BUS_WT_CLOCKB_EMUL_L = emul_q;
endmodule

// File: tb/tb_rk_bus_disk_write.sv
// tb_rk_bus_disk_write: directed bench with a scoreboard of expected write words
module tb_rk_bus_disk_write;
    logic clock = 1'b0, reset = 1'b1, gate_l = 1'b1, data_l = 1'b1, clkb_l = 1'b0;
    logic sel = 1'b0, real_drive = 1'b1, sector = 1'b0;
    logic wen, ld, ind, wsr, ecc, emul;
    logic [15:0] wdata;
    int compared = 0, mismatched = 0, wen_cnt = 0, ld_cnt = 0;
    logic prev_wen = 1'b0, prev_ld = 1'b0;
    logic [15:0] exp_q[$];
`ifdef ECC_CHECK_EN
    localparam logic ECC_ON = 1'b1;
`else
    localparam logic ECC_ON = 1'b0;
`endif

    rk_bus_disk_write dut (
        .clock(clock), .reset(reset), .BUS_WT_GATE_L(gate_l), .BUS_WT_DATA_CLK_L(data_l),
        .BUS_WT_CLOCKB_L(clkb_l), .Selected_Ready(sel), .real_drive(real_drive), .clkenbl_sector(sector),
        .dram_write_enbl_buswrite(wen), .dram_writedata_buswrite(wdata), .load_address_buswrite(ld),
        .write_indicator(ind), .write_selected_ready(wsr), .ECC_error(ecc), .BUS_WT_CLOCKB_EMUL_L(emul)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (wen) begin
                wen_cnt++;
                check("strobe_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("wdata", wdata, exp_q.pop_front());
                check("strobe_width", prev_wen, 0);
            end
            if (ld) begin
                ld_cnt++;
                check("ld_width", prev_ld, 0);
            end
            prev_wen = wen;
            prev_ld = ld;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        clkb_l = 1'b1;
        data_l = ~b;
        repeat (3) tick();
        clkb_l = 1'b0;
        data_l = 1'b1;
        tick();
        data_l = 1'b0;
        tick();
        data_l = 1'b1;
        tick();
    endtask

    task automatic send_word(input logic [19:0] v, input bit push);
        if (push) exp_q.push_back(v[19:4]);
        for (int i = 19; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic frame_start(input int nz);
        repeat (nz) send_bit(1'b0);
        repeat (4) send_bit(1'b1);
        send_bit(1'b0);
    endtask

    initial begin
        int n, hi;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_wen", wen, 0);
        check("rst_wdata", wdata, 0);
        check("rst_ld", ld, 0);
        check("rst_ind", ind, 0);
        check("rst_wsr", wsr, 0);
        check("rst_ecc", ecc, 0);
        check("rst_emul", emul, 1);

        gate_l = 1'b0;
        repeat (4) tick();
        frame_start(10);
        send_word({16'hA5A5, 4'h0}, 1'b0);
        repeat (6) tick();
        check("nsel_ld", ld_cnt, 0);
        check("nsel_wen", wen_cnt, 0);
        check("nsel_ind", ind, 0);
        check("nsel_wsr", wsr, 0);
        check("nsel_emul", emul, 1);

        gate_l = 1'b1;
        sel = 1'b1;
        repeat (4) tick();
        real_drive = 1'b0;
        gate_l = 1'b0;
        n = 0;
        do begin tick(); n++; end while (emul !== 1'b0 && n < 10);
        check("emul_start", n, 3);
        n = 0;
        do begin tick(); n++; end while (emul === 1'b0 && n < 100);
        check("emul_low", n, 29);
        n = 0;
        do begin tick(); n++; end while (emul === 1'b1 && n < 100);
        check("emul_high", n, 29);
        check("act_ind", ind, 1);
        check("act_wsr", wsr, 1);
        real_drive = 1'b1;
        repeat (2) tick();
        hi = 0;
        repeat (60) begin tick(); hi += int'(emul); end
        check("emul_real_drive", hi, 60);

        frame_start(188);
        repeat (5) tick();
        check("sync_ld", ld_cnt, 1);
        check("sync_no_wen", wen_cnt, 0);
        check("sync_ecc", ecc, 0);
        send_word({16'hA5A5, 4'h0}, 1'b1);
        send_word({16'h8001, 4'hC}, 1'b1);
        for (int i = 3; i <= 320; i++) send_word({16'h2490, 4'h0}, 1'b1);
        send_word({16'hFFFF, 4'h0}, 1'b1);
        send_word({16'h1234, 4'hE}, 1'b0);
        repeat (8) tick();
        check("sector_wen_cnt", wen_cnt, 321);
        check("sector_q_empty", exp_q.size(), 0);
        check("sector_ecc", ecc, 0);
        check("sector_ld_cnt", ld_cnt, 1);
        check("wdata_held", wdata, 16'hFFFF);

        gate_l = 1'b1;
        repeat (5) tick();
        check("gate_off_ind", ind, 0);
        gate_l = 1'b0;
        repeat (4) tick();
        frame_start(8);
        send_word({16'h8001, 4'h0}, 1'b1);
        repeat (6) tick();
        check("ecc_set", ecc, ECC_ON);
        send_word({16'hA5A5, 4'h0}, 1'b1);
        repeat (6) tick();
        check("ecc_sticky", ecc, ECC_ON);
        gate_l = 1'b1;
        repeat (5) tick();
        check("ecc_gate_off", ecc, ECC_ON);
        check("ecc_gate_off_ind", ind, 0);
        gate_l = 1'b0;
        repeat (4) tick();
        check("ecc_cleared", ecc, 0);
        check("regate_ind", ind, 1);

        frame_start(4);
        send_word({16'h1234, 4'hE}, 1'b1);
        repeat (10) send_bit(1'b1);
        sector = 1'b1;
        tick();
        sector = 1'b0;
        repeat (10) send_bit(1'b0);
        frame_start(4);
        send_word({16'h2490, 4'h0}, 1'b1);
        repeat (6) tick();
        check("sectpulse_wen_cnt", wen_cnt, 325);
        check("sectpulse_ld_cnt", ld_cnt, 4);
        check("sectpulse_ecc", ecc, 0);

        repeat (10) send_bit(1'b1);
        gate_l = 1'b1;
        repeat (10) send_bit(1'b1);
        repeat (6) tick();
        check("gate_mid_wen_cnt", wen_cnt, 325);
        check("gate_mid_ind", ind, 0);
        check("final_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
